// File: rtl/spi_pkg.sv
// Shared types and helpers for the multi-chip-select SPI master.
package spi_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Index width for a select bus; a single select still needs one bit.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period timer: tick every CLK_DIV enabled cycles, plus leading/trailing
// toggle strobes and the number of toggles already done in the current transfer.
module spi_clk_gen #(
    parameter int  CLK_DIV    = 4,
    parameter int  DATA_WIDTH = 8,
    localparam int EW         = $clog2(2*DATA_WIDTH+1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          clr_i,
    input  logic          edge_en_i,
    output logic          tick_o,
    output logic          lead_o,
    output logic          trail_o,
    output logic [EW-1:0] edge_idx_o
);
    localparam int             DCW       = $clog2(CLK_DIV+1);
    localparam logic [DCW-1:0] DIV_LAST  = DCW'(CLK_DIV-1);
    localparam logic [EW-1:0]  EDGE_LAST = EW'(2*DATA_WIDTH-1);

    logic [DCW-1:0] div_q, div_d;
    logic [EW-1:0]  edge_q, edge_d;
    logic           toggle;

    assign tick_o     = en_i && (div_q == DIV_LAST);
    assign toggle     = tick_o && edge_en_i;
    // An even count of completed toggles means the next one is a leading edge.
    assign lead_o     = toggle && !edge_q[0];
    assign trail_o    = toggle && edge_q[0];
    assign edge_idx_o = edge_q;

    always_comb begin
        div_d  = div_q;
        edge_d = edge_q;
        if (clr_i) begin
            div_d  = '0;
            edge_d = '0;
        end else begin
            if (en_i)   div_d  = tick_o ? '0 : div_q + 1'b1;
            if (toggle) edge_d = (edge_q == EDGE_LAST) ? '0 : edge_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q  <= '0;
            edge_q <= '0;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
        end
    end

endmodule

// File: rtl/spi_master_mc.sv
// Full-duplex MSB-first SPI master with per-transfer CPOL/CPHA and NUM_CS selects.
// Accepts a command only in IDLE; the received word comes back on a one-cycle strobe.
module spi_master_mc
    import spi_pkg::*;
#(
    parameter int  CLK_DIV    = 4,
    parameter int  DATA_WIDTH = 8,
    parameter int  NUM_CS     = 4,
    localparam int CSW        = clog2_min1(NUM_CS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic [CSW-1:0]        cs_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic [NUM_CS-1:0]     cs_n,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso
);
    localparam int            EW        = $clog2(2*DATA_WIDTH+1);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2*DATA_WIDTH-1);

    spi_state_t            state_q;
    spi_mode_t             mode_q;
    logic [DATA_WIDTH-1:0] tx_sh_q, rx_sh_q, rx_data_q;
    logic [NUM_CS-1:0]     cs_n_q;
    logic                  rx_valid_q, sclk_q, mosi_q;

    logic          tick, lead, trail, toggle, last_toggle, sample, shift;
    logic [EW-1:0] edge_idx;

    spi_clk_gen #(
        .CLK_DIV    (CLK_DIV),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_clk_gen (
        .clk        (clk),
        .rst        (rst),
        .en_i       (state_q != IDLE),
        .clr_i      (state_q == IDLE),
        .edge_en_i  (state_q == XFER),
        .tick_o     (tick),
        .lead_o     (lead),
        .trail_o    (trail),
        .edge_idx_o (edge_idx)
    );

    assign toggle      = lead | trail;
    assign last_toggle = toggle && (edge_idx == EDGE_LAST);
    assign sample      = mode_q.cpha ? trail : lead;
    // With cpha=0 the MSB is already on mosi from SETUP, so the final trailing edge shifts nothing.
    assign shift       = mode_q.cpha ? lead : (trail && !last_toggle);

    // Out-of-range indices match no bit and leave every select deasserted.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CSW-1:0] idx);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (int'(idx) == i) v[i] = 1'b0;
        end
        return v;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mode_q     <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            cs_n_q     <= '1;
            rx_valid_q <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tx_valid) begin
                        state_q     <= SETUP;
                        mode_q.cpol <= cpol;
                        mode_q.cpha <= cpha;
                        cs_n_q      <= cs_decode(cs_sel);
                        sclk_q      <= cpol;
                        if (cpha) begin
                            tx_sh_q <= tx_data;
                        end else begin
                            mosi_q  <= tx_data[DATA_WIDTH-1];
                            tx_sh_q <= tx_data << 1;
                        end
                    end
                end
                SETUP: begin
                    if (tick) state_q <= XFER;
                end
                XFER: begin
                    if (toggle) begin
                        sclk_q <= ~sclk_q;
                        if (sample) rx_sh_q <= {rx_sh_q[DATA_WIDTH-2:0], miso};
                        if (shift) begin
                            mosi_q  <= tx_sh_q[DATA_WIDTH-1];
                            tx_sh_q <= tx_sh_q << 1;
                        end
                        if (last_toggle) state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state_q    <= IDLE;
                        cs_n_q     <= '1;
                        rx_valid_q <= 1'b1;
                        rx_data_q  <= rx_sh_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign cs_n     = cs_n_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master_mc.sv
// Bench for spi_master_mc: one 8-bit/4-select instance at CLK_DIV=4 and one
// 16-bit/5-select instance at CLK_DIV=1, each talking to a protocol-level slave.
module tb_spi_master_mc;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       a_tx_valid, a_tx_ready, a_cpol, a_cpha, a_rx_valid, a_busy, a_sclk, a_mosi, a_miso;
    logic [7:0] a_tx_data, a_rx_data;
    logic [1:0] a_cs_sel;
    logic [3:0] a_cs_n;

    logic        b_tx_valid, b_tx_ready, b_cpol, b_cpha, b_rx_valid, b_busy, b_sclk, b_mosi, b_miso;
    logic [15:0] b_tx_data, b_rx_data;
    logic [2:0]  b_cs_sel;
    logic [4:0]  b_cs_n;

    spi_master_mc #(.CLK_DIV(4), .DATA_WIDTH(8), .NUM_CS(4)) dut_a (
        .clk(clk), .rst(rst), .tx_valid(a_tx_valid), .tx_ready(a_tx_ready), .tx_data(a_tx_data),
        .cs_sel(a_cs_sel), .cpol(a_cpol), .cpha(a_cpha), .rx_valid(a_rx_valid), .rx_data(a_rx_data),
        .busy(a_busy), .cs_n(a_cs_n), .sclk(a_sclk), .mosi(a_mosi), .miso(a_miso));

    spi_master_mc #(.CLK_DIV(1), .DATA_WIDTH(16), .NUM_CS(5)) dut_b (
        .clk(clk), .rst(rst), .tx_valid(b_tx_valid), .tx_ready(b_tx_ready), .tx_data(b_tx_data),
        .cs_sel(b_cs_sel), .cpol(b_cpol), .cpha(b_cpha), .rx_valid(b_rx_valid), .rx_data(b_rx_data),
        .busy(b_busy), .cs_n(b_cs_n), .sclk(b_sclk), .mosi(b_mosi), .miso(b_miso));

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Slave settings shared with the slave processes; changed only between transfers.
    logic [7:0]  a_sw, a_cap;
    logic        a_loop, a_pha;
    logic [15:0] b_sw, b_cap;
    logic        b_pha;

    // SPI slave: drives miso on its shift edges and captures mosi on its sample edges.
    initial begin : slave_a
        logic       sel_p, sclk_p, lead;
        logic [7:0] sh;
        int         n;
        sel_p = 1'b0; sclk_p = 1'b0; sh = '0; n = 0; a_miso = 1'b0; a_cap = '0;
        forever begin
            @(negedge clk);
            if (a_cs_n == 4'hF) begin
                a_miso = 1'b0;
            end else begin
                if (!sel_p) begin
                    n = 0; sh = a_sw; a_cap = '0;
                    if (!a_pha) begin a_miso = sh[7]; sh = sh << 1; end
                end else if (a_sclk != sclk_p) begin
                    n++;
                    lead = (n % 2) == 1;
                    if (lead ^ a_pha) a_cap = {a_cap[6:0], a_mosi};
                    else begin a_miso = sh[7]; sh = sh << 1; end
                end
                if (a_loop) a_miso = a_mosi;
            end
            sel_p  = (a_cs_n != 4'hF);
            sclk_p = a_sclk;
        end
    end

    initial begin : slave_b
        logic        sel_p, sclk_p, lead;
        logic [15:0] sh;
        int          n;
        sel_p = 1'b0; sclk_p = 1'b0; sh = '0; n = 0; b_miso = 1'b0; b_cap = '0;
        forever begin
            @(negedge clk);
            if (b_cs_n == 5'h1F) begin
                b_miso = 1'b0;
            end else begin
                if (!sel_p) begin
                    n = 0; sh = b_sw; b_cap = '0;
                    if (!b_pha) begin b_miso = sh[15]; sh = sh << 1; end
                end else if (b_sclk != sclk_p) begin
                    n++;
                    lead = (n % 2) == 1;
                    if (lead ^ b_pha) b_cap = {b_cap[14:0], b_mosi};
                    else begin b_miso = sh[15]; sh = sh << 1; end
                end
            end
            sel_p  = (b_cs_n != 5'h1F);
            sclk_p = b_sclk;
        end
    end

    // One transfer on instance A; inputs are scrambled right after the accept edge.
    task automatic xfer_a(input string tag, input logic [7:0] tx, input logic [1:0] cs,
                          input logic pol, input logic pha, input logic [7:0] sw, input logic loop,
                          input logic [7:0] exp_rx, input logic [3:0] exp_cs);
        int   cs_low, toggles, busy_cnt, multi;
        logic sclk_p, done;
        @(negedge clk);
        a_sw = sw; a_loop = loop; a_pha = pha;
        a_tx_data = tx; a_cs_sel = cs; a_cpol = pol; a_cpha = pha; a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        a_tx_data = 8'($urandom); a_cs_sel = 2'($urandom); a_cpol = 1'($urandom); a_cpha = 1'($urandom);
        check({tag, " setup sclk idle"}, a_sclk, pol);
        check({tag, " cs_n"}, a_cs_n, exp_cs);
        cs_low = 0; toggles = 0; busy_cnt = 0; multi = 0; sclk_p = a_sclk; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (a_cs_n != 4'hF) cs_low++;
            if ($countones(~a_cs_n) > 1) multi++;
            if (a_busy) busy_cnt++;
            if (a_sclk != sclk_p) toggles++;
            sclk_p = a_sclk;
            @(negedge clk);
            done = a_rx_valid;
        end
        check({tag, " rx_valid seen"}, done, 1);
        check({tag, " rx_data"}, a_rx_data, exp_rx);
        check({tag, " cs low cycles"}, cs_low, 72);
        check({tag, " busy cycles"}, busy_cnt, 72);
        check({tag, " sclk toggles"}, toggles, 16);
        check({tag, " one-hot cs"}, multi, 0);
        check({tag, " end sclk idle"}, a_sclk, pol);
        check({tag, " end cs_n"}, a_cs_n, 4'hF);
        check({tag, " tx_ready at rx"}, a_tx_ready, 1);
        if (!loop) check({tag, " slave got mosi"}, a_cap, tx);
        @(negedge clk);
        check({tag, " rx_valid one cycle"}, a_rx_valid, 0);
    endtask

    task automatic xfer_b(input string tag, input logic [15:0] tx, input logic [2:0] cs,
                          input logic pol, input logic pha, input logic [15:0] sw,
                          input logic [15:0] exp_rx, input logic [4:0] exp_cs, input int exp_low);
        int   cs_low, toggles, busy_cnt;
        logic sclk_p, done;
        @(negedge clk);
        b_sw = sw; b_pha = pha;
        b_tx_data = tx; b_cs_sel = cs; b_cpol = pol; b_cpha = pha; b_tx_valid = 1'b1;
        @(negedge clk);
        b_tx_valid = 1'b0;
        check({tag, " setup sclk idle"}, b_sclk, pol);
        cs_low = 0; toggles = 0; busy_cnt = 0; sclk_p = b_sclk; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (b_cs_n != exp_cs) cs_low += 1000;
            if (b_cs_n != 5'h1F) cs_low++;
            if (b_busy) busy_cnt++;
            if (b_sclk != sclk_p) toggles++;
            sclk_p = b_sclk;
            b_tx_data = 16'($urandom); b_cs_sel = 3'($urandom); b_cpol = 1'($urandom); b_cpha = 1'($urandom);
            @(negedge clk);
            done = b_rx_valid;
        end
        check({tag, " rx_valid seen"}, done, 1);
        check({tag, " rx_data"}, b_rx_data, exp_rx);
        check({tag, " cs low cycles"}, cs_low, exp_low);
        check({tag, " busy cycles"}, busy_cnt, 34);
        check({tag, " sclk toggles"}, toggles, 32);
        check({tag, " end sclk idle"}, b_sclk, pol);
        if (exp_cs != 5'h1F) check({tag, " slave got mosi"}, b_cap, tx);
        @(negedge clk);
        check({tag, " rx_valid one cycle"}, b_rx_valid, 0);
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [1:0] cs;
        logic       pol;
        logic       pha;
        logic [7:0] sw;
        logic       loop;
        logic [7:0] exp_rx;
        logic [3:0] exp_cs;
    } vec_t;

    vec_t vecs[6];
    int   t, rv;
    logic sp;

    initial begin
        vecs[0] = '{8'hA5, 2'd2, 1'b0, 1'b0, 8'h00, 1'b1, 8'hA5, 4'b1011};
        vecs[1] = '{8'h5A, 2'd0, 1'b0, 1'b1, 8'h3C, 1'b0, 8'h3C, 4'b1110};
        vecs[2] = '{8'h81, 2'd1, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h3C, 4'b1101};
        vecs[3] = '{8'h7E, 2'd3, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h3C, 4'b0111};
        vecs[4] = '{8'hC3, 2'd1, 1'b1, 1'b1, 8'h00, 1'b1, 8'hC3, 4'b1101};
        vecs[5] = '{8'h0F, 2'd0, 1'b0, 1'b0, 8'hF0, 1'b0, 8'hF0, 4'b1110};

        rst = 1'b1;
        a_tx_valid = 0; a_tx_data = 0; a_cs_sel = 0; a_cpol = 0; a_cpha = 0;
        b_tx_valid = 0; b_tx_data = 0; b_cs_sel = 0; b_cpol = 0; b_cpha = 0;
        a_sw = 0; a_loop = 0; a_pha = 0; b_sw = 0; b_pha = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset cs_n", a_cs_n, 4'hF);
        check("reset sclk", a_sclk, 0);
        check("reset mosi", a_mosi, 0);
        check("reset tx_ready", a_tx_ready, 1);
        check("reset busy", a_busy, 0);
        check("reset rx_valid", a_rx_valid, 0);
        check("reset rx_data", a_rx_data, 0);
        check("reset b cs_n", b_cs_n, 5'h1F);

        for (int i = 0; i < 6; i++)
            xfer_a($sformatf("vec%0d", i), vecs[i].tx, vecs[i].cs, vecs[i].pol, vecs[i].pha,
                   vecs[i].sw, vecs[i].loop, vecs[i].exp_rx, vecs[i].exp_cs);

        for (int i = 0; i < 12; i++) begin
            logic [7:0] tx, sw;
            logic [1:0] cs;
            logic       pol, pha;
            tx = 8'($urandom); sw = 8'($urandom); cs = 2'($urandom_range(0, 3));
            pol = 1'($urandom); pha = 1'($urandom);
            xfer_a($sformatf("rand%0d", i), tx, cs, pol, pha, sw, 1'b0, sw, ~(4'b0001 << cs));
        end

        // Back-to-back: tx_valid stays high across two words.
        @(negedge clk);
        a_sw = 8'h3C; a_loop = 0; a_pha = 0;
        a_tx_data = 8'h11; a_cs_sel = 2'd1; a_cpol = 0; a_cpha = 0; a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_data = 8'h22;
        rv = 0;
        for (int c = 0; c < 200 && !a_rx_valid; c++) @(negedge clk);
        check("b2b first rx_valid", a_rx_valid, 1);
        check("b2b first rx_data", a_rx_data, 8'h3C);
        check("b2b first capture", a_cap, 8'h11);
        check("b2b tx_ready with rx_valid", a_tx_ready, 1);
        check("b2b cs gap", a_cs_n, 4'hF);
        @(negedge clk);
        a_tx_valid = 1'b0;
        check("b2b second accepted", a_busy, 1);
        check("b2b second cs_n", a_cs_n, 4'b1101);
        for (int c = 0; c < 200 && !a_rx_valid; c++) @(negedge clk);
        check("b2b second rx_valid", a_rx_valid, 1);
        check("b2b second rx_data", a_rx_data, 8'h3C);
        check("b2b second capture", a_cap, 8'h22);

        // Reset while bit 3 is on the wire, with cpol=1 so sclk is high at that moment.
        @(negedge clk);
        a_sw = 8'h96; a_loop = 0; a_pha = 0;
        a_tx_data = 8'hF0; a_cs_sel = 2'd0; a_cpol = 1; a_cpha = 0; a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        t = 0; sp = a_sclk;
        for (int c = 0; c < 200 && t < 6; c++) begin
            @(negedge clk);
            if (a_sclk != sp) t++;
            sp = a_sclk;
        end
        check("rst reached bit 3", t, 6);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst cs_n", a_cs_n, 4'hF);
        check("rst sclk", a_sclk, 0);
        check("rst mosi", a_mosi, 0);
        check("rst tx_ready", a_tx_ready, 1);
        check("rst rx_data", a_rx_data, 0);
        rv = a_rx_valid;
        repeat (80) begin
            @(negedge clk);
            rv += a_rx_valid;
        end
        check("rst no rx_valid", rv, 0);
        xfer_a("post-rst", 8'h69, 2'd3, 1'b0, 1'b0, 8'hB4, 1'b0, 8'hB4, 4'b0111);

        // CLK_DIV=1, 16-bit instance, including out-of-range selects.
        xfer_b("w16 mode0", 16'h8001, 3'd3, 1'b0, 1'b0, 16'h1234, 16'h1234, 5'b10111, 34);
        xfer_b("w16 mode3", 16'h8001, 3'd0, 1'b1, 1'b1, 16'h1234, 16'h1234, 5'b11110, 34);
        xfer_b("w16 mode1", 16'hBEEF, 3'd4, 1'b0, 1'b1, 16'hC0DE, 16'hC0DE, 5'b01111, 34);
        xfer_b("cs5 unused", 16'h8001, 3'd5, 1'b1, 1'b0, 16'h1234, 16'h0000, 5'h1F, 0);
        xfer_b("cs7 unused", 16'h5555, 3'd7, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 5'h1F, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1);
    end

endmodule
